// File: rtl/tx_seq_pkg.sv
// Shared state encodings, register bundle and default timing constants for the
// GTX TX reset sequencer.
package tx_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_GTX_RESET,
    ST_WAIT_RST_DONE,
    ST_WAIT_SYNC,
    ST_READY,
    ST_RETRY,
    ST_FAIL
  } seq_state_t;

  localparam int unsigned CNT_W         = 24;
  localparam int unsigned NLANES_DEF    = 4;
  localparam int unsigned LOCK_WAIT_DEF = 1024;
  localparam int unsigned RST_LEN_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF   = 20000;
  localparam int unsigned MAX_RETRY_DEF = 3;

  // Every flop of the sequencer, so the TMR build can triplicate and vote it as one word.
  typedef struct packed {
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry;
    logic             gtx_rst;
    logic             sync_rst;
    logic             ready;
    logic             fail;
  } seq_regs_t;

  localparam seq_regs_t SEQ_RESET = '{
    state:    ST_IDLE,
    cnt:      '0,
    retry:    '0,
    gtx_rst:  1'b1,
    sync_rst: 1'b1,
    ready:    1'b0,
    fail:     1'b0
  };

endpackage

// File: rtl/tx_seq_vote.sv
// Bitwise 3-input majority voter used by the TMR build of tx_rst_seq.
module tx_seq_vote #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tx_rst_seq.sv
// GTX TX reset/phase-align sequencer with bounded retries.
// Define TX_RST_SEQ_TMR_EN to triplicate all registers behind majority voters.
module tx_rst_seq
  import tx_seq_pkg::*;
#(
  parameter int unsigned NLANES    = NLANES_DEF,
  parameter int unsigned LOCK_WAIT = LOCK_WAIT_DEF,
  parameter int unsigned RST_LEN   = RST_LEN_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PLLLKDET,
  input  logic [NLANES-1:0] TXRESETDONE,
  input  logic [NLANES-1:0] SYNC_DONE,
  output logic              GTXTXRESET,
  output logic              SYNC_RST,
  output logic              TX_READY,
  output logic              TX_FAIL,
  output logic [3:0]        RETRY_CNT
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  seq_regs_t  cur;
  seq_regs_t  nxt;
  seq_state_t st_n;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]       retry_n;

  always_comb begin
    st_n    = cur.state;
    cnt_n   = cur.cnt + CNT_W'(1);
    retry_n = cur.retry;
    // Each branch tests lock loss first, then completion, then timeout.
    case (cur.state)
      ST_IDLE:      st_n = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (!PLLLKDET)              cnt_n = '0;
        else if (cur.cnt == LOCK_LAST) st_n = ST_GTX_RESET;
      end
      ST_GTX_RESET: begin
        if (!PLLLKDET)                st_n = ST_WAIT_LOCK;
        else if (cur.cnt == RST_LAST) st_n = ST_WAIT_RST_DONE;
      end
      ST_WAIT_RST_DONE: begin
        if (!PLLLKDET)               st_n = ST_WAIT_LOCK;
        else if (&TXRESETDONE)       st_n = ST_WAIT_SYNC;
        else if (cur.cnt == TO_LAST) st_n = ST_RETRY;
      end
      ST_WAIT_SYNC: begin
        if (!PLLLKDET)               st_n = ST_WAIT_LOCK;
        else if (&SYNC_DONE)         st_n = ST_READY;
        else if (cur.cnt == TO_LAST) st_n = ST_RETRY;
      end
      ST_READY: begin
        cnt_n = '0;
        if (!PLLLKDET) st_n = ST_WAIT_LOCK;
      end
      ST_RETRY: begin
        retry_n = (cur.retry == 4'hF) ? 4'hF : cur.retry + 4'd1;
        st_n    = (32'(retry_n) >= MAX_RETRY) ? ST_FAIL : ST_GTX_RESET;
      end
      ST_FAIL:  cnt_n = '0;
      default:  st_n = ST_IDLE;
    endcase
    if (st_n != cur.state) cnt_n = '0;

    nxt.state    = st_n;
    nxt.cnt      = cnt_n;
    nxt.retry    = retry_n;
    nxt.gtx_rst  = (st_n == ST_IDLE) || (st_n == ST_WAIT_LOCK) ||
                   (st_n == ST_GTX_RESET) || (st_n == ST_FAIL);
    nxt.sync_rst = (st_n != ST_WAIT_SYNC) && (st_n != ST_READY);
    nxt.ready    = (st_n == ST_READY);
    nxt.fail     = (st_n == ST_FAIL);
  end

`ifdef TX_RST_SEQ_TMR_EN
  seq_regs_t r0, r1, r2;

  // All copies reload from the voted value, so one upset copy heals on the next edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r0 <= SEQ_RESET;
      r1 <= SEQ_RESET;
      r2 <= SEQ_RESET;
    end else begin
      r0 <= nxt;
      r1 <= nxt;
      r2 <= nxt;
    end
  end

  tx_seq_vote #(.W($bits(seq_regs_t))) u_vote (
    .a(r0),
    .b(r1),
    .c(r2),
    .y(cur)
  );
`else
  seq_regs_t r0;

  always_ff @(posedge CLK) begin
    if (RST) r0 <= SEQ_RESET;
    else     r0 <= nxt;
  end

  assign cur = r0;
`endif

  assign GTXTXRESET = cur.gtx_rst;
  assign SYNC_RST   = cur.sync_rst;
  assign TX_READY   = cur.ready;
  assign TX_FAIL    = cur.fail;
  assign RETRY_CNT  = cur.retry;

endmodule

// File: tb/tb_tx_rst_seq.sv
// Self-checking bench for tx_rst_seq: directed vector table, hand-written corner
// sequences and a randomized run against a phase/elapsed-time reference model.
module tb_tx_rst_seq;
  import tx_seq_pkg::*;

  localparam int LW = 8;
  localparam int RL = 16;
  localparam int TO = 100;
  localparam int MR = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PLLLKDET;
  logic [3:0] TXRESETDONE;
  logic [3:0] SYNC_DONE;
  logic       GTXTXRESET;
  logic       SYNC_RST;
  logic       TX_READY;
  logic       TX_FAIL;
  logic [3:0] RETRY_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  tx_rst_seq #(
    .NLANES(4),
    .LOCK_WAIT(LW),
    .RST_LEN(RL),
    .TIMEOUT(TO),
    .MAX_RETRY(MR)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .PLLLKDET(PLLLKDET),
    .TXRESETDONE(TXRESETDONE),
    .SYNC_DONE(SYNC_DONE),
    .GTXTXRESET(GTXTXRESET),
    .SYNC_RST(SYNC_RST),
    .TX_READY(TX_READY),
    .TX_FAIL(TX_FAIL),
    .RETRY_CNT(RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  // Expected/actual word: {GTXTXRESET, SYNC_RST, TX_READY, TX_FAIL, RETRY_CNT}
  function automatic logic [7:0] outs();
    return {GTXTXRESET, SYNC_RST, TX_READY, TX_FAIL, RETRY_CNT};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got gtx/sync/rdy/fail/retry=%b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit pll, input logic [3:0] trd, input logic [3:0] sd);
    RST         = rst;
    PLLLKDET    = pll;
    TXRESETDONE = trd;
    SYNC_DONE   = sd;
  endtask

  typedef struct {
    string       name;
    bit          rst;
    bit          pll;
    logic [3:0]  trd;
    logic [3:0]  sd;
    int unsigned cyc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string n, input bit rst, input bit pll,
                              input logic [3:0] trd, input logic [3:0] sd, input int unsigned cyc,
                              input bit g, input bit s, input bit r, input bit f, input logic [3:0] ret);
    vq.push_back('{name: n, rst: rst, pll: pll, trd: trd, sd: sd, cyc: cyc,
                   exp: {g, s, r, f, ret}});
  endfunction

  // Reference model: current phase, edges spent in it, consecutive lock samples.
  localparam int P_IDLE = 0, P_LOCK = 1, P_RST = 2, P_RDONE = 3,
                 P_SYNC = 4, P_READY = 5, P_RETRY = 6, P_FAIL = 7;
  int m_ph, m_t, m_run, m_ret;

  task automatic model_step(input bit rst, input bit pll, input logic [3:0] trd, input logic [3:0] sd);
    int nph;
    if (rst) begin
      m_ph = P_IDLE; m_t = 0; m_run = 0; m_ret = 0;
      return;
    end
    nph = m_ph;
    m_t++;
    m_run = pll ? m_run + 1 : 0;
    case (m_ph)
      P_IDLE:  nph = P_LOCK;
      P_LOCK:  if (m_run >= LW) nph = P_RST;
      P_RST:   if (!pll) nph = P_LOCK; else if (m_t >= RL) nph = P_RDONE;
      P_RDONE: if (!pll) nph = P_LOCK; else if (trd == 4'hF) nph = P_SYNC;
               else if (m_t >= TO) nph = P_RETRY;
      P_SYNC:  if (!pll) nph = P_LOCK; else if (sd == 4'hF) nph = P_READY;
               else if (m_t >= TO) nph = P_RETRY;
      P_READY: if (!pll) nph = P_LOCK;
      P_RETRY: begin
        m_ret = (m_ret < 15) ? m_ret + 1 : 15;
        nph   = (m_ret >= MR) ? P_FAIL : P_RST;
      end
      default: ;
    endcase
    if (nph != m_ph) begin
      m_t = 0; m_run = 0;
    end
    m_ph = nph;
  endtask

  function automatic logic [7:0] model_outs();
    logic g, s, r, f;
    logic [3:0] ret;
    g   = (m_ph == P_IDLE) || (m_ph == P_LOCK) || (m_ph == P_RST) || (m_ph == P_FAIL);
    s   = !((m_ph == P_SYNC) || (m_ph == P_READY));
    r   = (m_ph == P_READY);
    f   = (m_ph == P_FAIL);
    ret = 4'(m_ret);
    return {g, s, r, f, ret};
  endfunction

  initial begin
    bit rb, pb;
    logic [3:0] tb_trd, tb_sd;

    drive(1'b1, 1'b1, 4'h0, 4'h0);

    // Nominal bring-up, lock loss in Ready and resequence
    add("rst",          1, 1, 4'h0, 4'h0,  2, 1, 1, 0, 0, 4'd0);
    add("wlock",        0, 1, 4'h0, 4'h0,  1, 1, 1, 0, 0, 4'd0);
    add("lock_done",    0, 1, 4'h0, 4'h0,  8, 1, 1, 0, 0, 4'd0);
    add("gtx_hold",     0, 1, 4'h0, 4'h0, 15, 1, 1, 0, 0, 4'd0);
    add("gtx_fall",     0, 1, 4'h0, 4'h0,  1, 0, 1, 0, 0, 4'd0);
    add("rstdone_wait", 0, 1, 4'h0, 4'h0,  4, 0, 1, 0, 0, 4'd0);
    add("to_sync",      0, 1, 4'hF, 4'h0,  1, 0, 0, 0, 0, 4'd0);
    add("sync_wait",    0, 1, 4'hF, 4'h0, 39, 0, 0, 0, 0, 4'd0);
    add("ready",        0, 1, 4'hF, 4'hF,  1, 0, 0, 1, 0, 4'd0);
    add("ready_hold",   0, 1, 4'hF, 4'hF, 10, 0, 0, 1, 0, 4'd0);
    add("lock_loss",    0, 0, 4'hF, 4'hF,  1, 1, 1, 0, 0, 4'd0);
    add("relock_gtx",   0, 1, 4'hF, 4'hF, 23, 1, 1, 0, 0, 4'd0);
    add("relock_fall",  0, 1, 4'hF, 4'hF,  1, 0, 1, 0, 0, 4'd0);
    add("resync",       0, 1, 4'hF, 4'hF,  1, 0, 0, 0, 0, 4'd0);
    add("reready",      0, 1, 4'hF, 4'hF,  1, 0, 0, 1, 0, 4'd0);
    // Lock loss beats completion in Wait_Sync
    add("ll2",          0, 0, 4'hF, 4'h7,  1, 1, 1, 0, 0, 4'd0);
    add("ws2",          0, 1, 4'hF, 4'h7, 25, 0, 0, 0, 0, 4'd0);
    add("ll_vs_done",   0, 0, 4'hF, 4'hF,  1, 1, 1, 0, 0, 4'd0);
    // Lock glitch restarts the consecutive-lock count
    add("rst2",         1, 1, 4'h0, 4'h0,  1, 1, 1, 0, 0, 4'd0);
    add("wl2",          0, 1, 4'h0, 4'h0,  6, 1, 1, 0, 0, 4'd0);
    add("glitch",       0, 0, 4'h0, 4'h0,  1, 1, 1, 0, 0, 4'd0);
    add("relock_early", 0, 1, 4'h0, 4'h0, 23, 1, 1, 0, 0, 4'd0);
    add("relock_exit",  0, 1, 4'h0, 4'h0,  1, 0, 1, 0, 0, 4'd0);
    // Stuck SYNC_DONE: three retries then Fail, cleared only by RST
    add("rst3",         1, 1, 4'hF, 4'h7,  1, 1, 1, 0, 0, 4'd0);
    add("ws3",          0, 1, 4'hF, 4'h7, 26, 0, 0, 0, 0, 4'd0);
    add("ws3_hold",     0, 1, 4'hF, 4'h7, 99, 0, 0, 0, 0, 4'd0);
    add("retry1",       0, 1, 4'hF, 4'h7,  1, 0, 1, 0, 0, 4'd0);
    add("gtx_r1",       0, 1, 4'hF, 4'h7,  1, 1, 1, 0, 0, 4'd1);
    add("retry2",       0, 1, 4'hF, 4'h7,117, 0, 1, 0, 0, 4'd1);
    add("gtx_r2",       0, 1, 4'hF, 4'h7,  1, 1, 1, 0, 0, 4'd2);
    add("retry3",       0, 1, 4'hF, 4'h7,117, 0, 1, 0, 0, 4'd2);
    add("fail",         0, 1, 4'hF, 4'h7,  1, 1, 1, 0, 1, 4'd3);
    add("fail_hold",    0, 1, 4'hF, 4'hF, 30, 1, 1, 0, 1, 4'd3);
    add("fail_rst",     1, 1, 4'hF, 4'h7,  1, 1, 1, 0, 0, 4'd0);
    // Completion on the timeout edge wins
    add("ws4",          0, 1, 4'hF, 4'h0, 26, 0, 0, 0, 0, 4'd0);
    add("ws4_hold",     0, 1, 4'hF, 4'h0, 99, 0, 0, 0, 0, 4'd0);
    add("tie",          0, 1, 4'hF, 4'hF,  1, 0, 0, 1, 0, 4'd0);
    add("tie_hold",     0, 1, 4'hF, 4'hF,  5, 0, 0, 1, 0, 4'd0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].pll, vq[i].trd, vq[i].sd);
      repeat (vq[i].cyc) @(posedge CLK);
      #1;
      check(vq[i].name, outs(), vq[i].exp);
    end

    // RST mid-sequence while Ready
    drive(1'b1, 1'b1, 4'hF, 4'hF);
    @(posedge CLK); #1;
    check("rst_from_ready", outs(), 8'b1100_0000);

`ifdef TX_RST_SEQ_TMR_EN
    // Upset one state copy in Wait_Sync: outputs hold, copy heals on the next edge
    drive(1'b1, 1'b1, 4'hF, 4'h0);
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, 4'hF, 4'h0);
    repeat (26) @(posedge CLK);
    #1;
    check("tmr_ws", outs(), 8'b0000_0000);
    dut.r1.state = ST_FAIL;
    #1;
    check("tmr_upset_out", outs(), 8'b0000_0000);
    @(posedge CLK); #1;
    check("tmr_after_out", outs(), 8'b0000_0000);
    check("tmr_resync", {5'b0, dut.r1.state}, {5'b0, ST_WAIT_SYNC});
`endif

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      rb     = (i == 0) || ($urandom_range(0, 299) == 0);
      pb     = ($urandom_range(0, 99) != 0);
      tb_trd = ($urandom_range(0, 29) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      tb_sd  = ($urandom_range(0, 59) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      drive(rb, pb, tb_trd, tb_sd);
      @(posedge CLK); #1;
      model_step(rb, pb, tb_trd, tb_sd);
      check("rand", outs(), model_outs());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
